// File: rtl/fetch_stage.sv
// Pipeline front end: PC register, instruction-memory addressing and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds stall/flush cycle counters.
module fetch_stage #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [31:0]        NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [ADDR_W-1:0] if_id_pc_plus4,
  output logic [31:0]       if_id_instr,
  output logic              if_id_valid,
  output logic [4:0]        if_id_RegisterRs1,
  output logic [4:0]        if_id_RegisterRs2
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_cycles
`endif
);

  localparam logic [ADDR_W-1:0] PcStep = {{(ADDR_W-3){1'b0}}, 3'b100};

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
  logic [ADDR_W-1:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic [31:0]       if_id_instr_q, if_id_instr_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic [ADDR_W-1:0] pc_plus4;

  assign pc_plus4 = pc_q + PcStep;

  always_comb begin
    pc_d             = pc_q;
    if_id_pc_d       = if_id_pc_q;
    if_id_pc_plus4_d = if_id_pc_plus4_q;
    if_id_instr_d    = if_id_instr_q;
    if_id_valid_d    = if_id_valid_q;
    if (branch_taken) begin
      // The redirect beats a stall: the held ID instruction is on the wrong path.
      pc_d          = {branch_target[ADDR_W-1:2], 2'b00};
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d             = pc_plus4;
      if_id_pc_d       = pc_q;
      if_id_pc_plus4_d = pc_plus4;
      if_id_instr_d    = imem_rdata;
      if_id_valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q             <= RESET_PC;
      if_id_pc_q       <= RESET_PC;
      if_id_pc_plus4_q <= RESET_PC + PcStep;
      if_id_instr_q    <= NOP_INSTR;
      if_id_valid_q    <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_valid_q    <= if_id_valid_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_pc_plus4 = if_id_pc_plus4_q;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_valid    = if_id_valid_q;

  // Bubbles report x0 so they can never raise a load-use stall.
  assign if_id_RegisterRs1 = if_id_valid_q ? if_id_instr_q[19:15] : 5'd0;
  assign if_id_RegisterRs2 = if_id_valid_q ? if_id_instr_q[24:20] : 5'd0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      if (stall && !branch_taken) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (branch_taken)           flush_cycles_q <= flush_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: reference model feeds a scoreboard queue,
// each clock edge pops one expected state and compares every output.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr;
  logic        if_id_valid;
  logic [4:0]  if_id_RegisterRs1, if_id_RegisterRs2;
  logic        use_const;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] p4;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [31:0] m_pc, m_ifpc, m_p4, m_instr, m_scnt, m_fcnt;
  logic        m_valid;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic c, input logic [31:0] a);
    return c ? 32'h0050_0093 : ((a * 32'h9E37_79B1) ^ 32'h0F0F_0F0F);
  endfunction

  assign imem_rdata = mem_word(use_const, imem_addr);

  fetch_stage dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .if_id_pc          (if_id_pc),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_instr       (if_id_instr),
    .if_id_valid       (if_id_valid),
    .if_id_RegisterRs1 (if_id_RegisterRs1),
    .if_id_RegisterRs2 (if_id_RegisterRs2)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles      (stall_cycles),
    .flush_cycles      (flush_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the model's prediction, then pop and compare.
  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] tgt);
    exp_t e;
    exp_t got;
    rst = r; stall = s; branch_taken = b; branch_target = tgt;
    if (r) begin
      m_pc = 32'h0; m_ifpc = 32'h0; m_p4 = 32'h4; m_instr = 32'h13; m_valid = 1'b0;
      m_scnt = 32'h0; m_fcnt = 32'h0;
    end else begin
      if (s && !b) m_scnt = m_scnt + 32'd1;
      if (b) begin
        m_fcnt = m_fcnt + 32'd1;
        m_pc = {tgt[31:2], 2'b00}; m_instr = 32'h13; m_valid = 1'b0;
      end else if (!s) begin
        m_ifpc = m_pc; m_p4 = m_pc + 32'd4; m_instr = mem_word(use_const, m_pc);
        m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end
    end
    e.pc = m_pc; e.ifpc = m_ifpc; e.p4 = m_p4; e.instr = m_instr; e.valid = m_valid;
    e.scnt = m_scnt; e.fcnt = m_fcnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("imem_addr", imem_addr, got.pc);
    chk("if_id_pc", if_id_pc, got.ifpc);
    chk("if_id_pc_plus4", if_id_pc_plus4, got.p4);
    chk("if_id_instr", if_id_instr, got.instr);
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, got.valid});
    chk("rs1", {27'd0, if_id_RegisterRs1}, got.valid ? {27'd0, got.instr[19:15]} : 32'd0);
    chk("rs2", {27'd0, if_id_RegisterRs2}, got.valid ? {27'd0, got.instr[24:20]} : 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, got.scnt);
    chk("flush_cycles", flush_cycles, got.fcnt);
`endif
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; use_const = 1'b1;
    m_pc = 32'h0; m_ifpc = 32'h0; m_p4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
    m_scnt = 32'h0; m_fcnt = 32'h0;

    // Reset state
    step(1, 0, 0, 0);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_instr", if_id_instr, 32'h0000_0013);
    chk("reset_valid", {31'd0, if_id_valid}, 32'd0);

    // Three free-run cycles with a constant instruction word
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("run_addr", imem_addr, 32'hC);
    chk("run_if_pc", if_id_pc, 32'h8);
    chk("run_rs2", {27'd0, if_id_RegisterRs2}, 32'd5);

    // Stall for two edges at PC=0x8, then release
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("stall1_addr", imem_addr, 32'h8);
    step(0, 1, 0, 0);
    chk("stall2_addr", imem_addr, 32'h8);
    chk("stall2_if_pc", if_id_pc, 32'h4);
    step(0, 0, 0, 0);
    chk("release_addr", imem_addr, 32'hC);
    chk("release_if_pc", if_id_pc, 32'h8);

    // Address-dependent instruction words
    use_const = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // Branch while stalled; low target bits are dropped
    step(0, 1, 1, 32'h103);
    chk("br_addr", imem_addr, 32'h100);
    chk("br_instr", if_id_instr, 32'h13);
    chk("br_valid", {31'd0, if_id_valid}, 32'd0);
    step(0, 0, 0, 0);

    // Back-to-back redirects, then wrap around the top of the address space
    step(0, 0, 1, 32'hFFFF_FFF0);
    step(0, 0, 1, 32'hFFFF_FFFE);
    chk("b2b_valid", {31'd0, if_id_valid}, 32'd0);
    chk("b2b_addr", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_plus4", if_id_pc_plus4, 32'h0);
    step(0, 0, 0, 0);

    // Reset wins over stall and redirect
    step(0, 1, 0, 0);
    step(1, 1, 1, 32'h400);
    chk("rst_mid_addr", imem_addr, 32'h0);
    chk("rst_mid_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_mid_instr", if_id_instr, 32'h13);
    step(0, 0, 0, 0);

    // Three stall cycles and two redirects, one overlapping a stall
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 32'h40);
    step(0, 1, 0, 0);
    step(0, 0, 1, 32'h80);
    step(0, 0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall", stall_cycles, 32'd2);
    chk("perf_flush", flush_cycles, 32'd2);
`endif
    chk("perf_seq_addr", imem_addr, 32'h84);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
